// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: the active-low glyph table used by both the
// forward hex-to-segment decoder and the scan decoder, plus the reverse lookup.
package seg7_pkg;

    localparam int SEG_W = 7;

    // Decoded glyph: bad=1 means the pattern is not one of the 16 hex glyphs.
    typedef struct packed {
        logic       bad;
        logic [3:0] nib;
    } glyph_t;

    // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by hex value.
    localparam logic [SEG_W-1:0] GLYPH_TABLE [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Unknown patterns decode to nibble 0 with the bad flag raised.
    function automatic glyph_t seg_to_hex(input logic [SEG_W-1:0] seg);
        glyph_t g;
        g.bad = 1'b1;
        g.nib = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH_TABLE[i]) begin
                g.bad = 1'b0;
                g.nib = 4'(i);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/seg_dwell_filter.sv
// Registers the multiplexed segment bus and emits a single capture strobe per
// stable, legal digit dwell, with the one-hot digit position and its pattern.
module seg_dwell_filter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEG_W-1:0]      seg_in,
    input  logic [NUM_DIGITS-1:0] an_in,
    output logic                  cap_valid,
    output logic [NUM_DIGITS-1:0] cap_sel,
    output logic [SEG_W-1:0]      cap_seg
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(STABLE_CYCLES);

    logic [SEG_W-1:0]            seg_q;
    logic [NUM_DIGITS-1:0]       an_q;
    logic [NUM_DIGITS+SEG_W-1:0] prev_pair;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_next;
    logic                        armed;
    logic                        arm_eff;
    logic                        legal;
    logic                        changed;

    always_comb begin
        legal   = ($countones(~an_q) == 1);
        changed = ({an_q, seg_q} != prev_pair);
    end

    // A change both restarts the count and re-arms, so a dwell whose very
    // first sample completes the count (STABLE_CYCLES=1) still captures.
    always_comb begin
        cnt_next  = '0;
        arm_eff   = 1'b0;
        cap_valid = 1'b0;
        if (legal) begin
            arm_eff = armed | changed;
            if (changed) begin
                cnt_next = CNT_W'(1);
            end else if (cnt == CNT_TOP) begin
                cnt_next = cnt;
            end else begin
                cnt_next = cnt + 1'b1;
            end
            cap_valid = arm_eff && (cnt_next == CNT_TOP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q     <= '0;
            an_q      <= '0;
            prev_pair <= '0;
            cnt       <= '0;
            armed     <= 1'b0;
        end else begin
            seg_q     <= seg_in;
            an_q      <= an_in;
            prev_pair <= {an_q, seg_q};
            cnt       <= cnt_next;
            armed     <= arm_eff & ~cap_valid;
        end
    end

    always_comb begin
        cap_sel = ~an_q;
        cap_seg = seg_q;
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the hex digits shown on a multiplexed active-low 7-segment bus and
// publishes each complete frame through a valid/ready output register.
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   bad_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_PUBLISH = 1'b1;

    logic [0:0]              state;
    logic [0:0]              state_next;
    logic                    cap_valid;
    logic [NUM_DIGITS-1:0]   cap_sel;
    logic [SEG_W-1:0]        cap_seg;
    glyph_t                  cap_glyph;
    logic [4*NUM_DIGITS-1:0] work_hex;
    logic [4*NUM_DIGITS-1:0] work_hex_next;
    logic [NUM_DIGITS-1:0]   work_bad;
    logic [NUM_DIGITS-1:0]   work_bad_next;
    logic [NUM_DIGITS-1:0]   captured;
    logic [NUM_DIGITS-1:0]   captured_next;
    logic                    publish;
    logic                    load;

    seg_dwell_filter #(
        .NUM_DIGITS   (NUM_DIGITS),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .seg_in   (seg_in),
        .an_in    (an_in),
        .cap_valid(cap_valid),
        .cap_sel  (cap_sel),
        .cap_seg  (cap_seg)
    );

    always_comb cap_glyph = seg_to_hex(cap_seg);

    // A capture landing in the PUBLISH cycle starts the next frame rather
    // than being lost with the cleared mask.
    always_comb begin
        work_hex_next = work_hex;
        work_bad_next = work_bad;
        captured_next = (state == ST_PUBLISH) ? '0 : captured;
        if (cap_valid) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_sel[i]) begin
                    work_hex_next[4*i +: 4] = cap_glyph.nib;
                    work_bad_next[i]        = cap_glyph.bad;
                    captured_next[i]        = 1'b1;
                end
            end
        end
        state_next = (&captured_next) ? ST_PUBLISH : ST_COLLECT;
    end

    // Handshake: a frame transfers on any edge where out_valid && out_ready.
    // out_valid stays high until that transfer; while it is high and
    // out_ready is low, hex_out/bad_out hold and a newly completed frame is
    // dropped (overrun, sticky). A publish coinciding with a transfer
    // replaces the frame and keeps out_valid high.
    always_comb begin
        publish = (state == ST_PUBLISH);
        load    = publish && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_COLLECT;
            captured  <= '0;
            work_hex  <= '0;
            work_bad  <= '0;
            hex_out   <= '0;
            bad_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            captured  <= captured_next;
            work_hex  <= work_hex_next;
            work_bad  <= work_bad_next;
            out_valid <= load | (out_valid & ~out_ready);
            if (load) begin
                hex_out <= work_hex;
                bad_out <= work_bad;
            end
            if (publish && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed stimulus for seg_scan_decoder, checked every cycle
// against a run-length / frame-queue model of the display bus.
module tb_seg_scan_decoder;

    localparam int ND     = 4;
    localparam int STABLE = 4;

    localparam logic [6:0] G [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    // clock / reset
    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg_in;
    logic [ND-1:0] an_in;
    logic          out_ready;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0] bad_out;
    logic          out_valid;
    logic          overrun;

    always #5 clk = ~clk;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_in   (seg_in),
        .an_in    (an_in),
        .hex_out  (hex_out),
        .bad_out  (bad_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int v_cnt    = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // reference model
    function automatic void m_decode(input logic [6:0] s, output logic [3:0] n, output logic b);
        n = 4'h0;
        b = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (s == G[k]) begin
                n = 4'(k);
                b = 1'b0;
            end
        end
    endfunction

    int          run;
    logic [10:0] last_pair;
    bit          cap_pend;
    int          cap_idx;
    logic [6:0]  cap_segv;
    logic [3:0]  m_work [ND];
    logic        m_wbad [ND];
    bit          m_got  [ND];
    bit          pub_pend;
    logic [4*ND-1:0] m_hex;
    logic [ND-1:0]   m_bad;
    bit          m_valid;
    bit          m_ovr;

    // Model: a digit is captured one edge after its bus pattern has been
    // sampled on STABLE consecutive edges; a frame is presented one edge
    // after every position has been captured.
    always @(posedge clk) begin : model
        int zc;
        int zi;
        bit all_got;
        logic [3:0] dn;
        logic db;
        if (rst) begin
            run = 0;
            last_pair = '0;
            cap_pend = 1'b0;
            pub_pend = 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_work[i] = 4'h0;
                m_wbad[i] = 1'b0;
                m_got[i]  = 1'b0;
            end
            m_hex = '0;
            m_bad = '0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
        end else begin
            if (pub_pend) begin
                if (!m_valid || out_ready) begin
                    for (int i = 0; i < ND; i++) begin
                        m_hex[4*i +: 4] = m_work[i];
                        m_bad[i] = m_wbad[i];
                    end
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                for (int i = 0; i < ND; i++) m_got[i] = 1'b0;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            pub_pend = 1'b0;
            if (cap_pend) begin
                m_decode(cap_segv, dn, db);
                m_work[cap_idx] = dn;
                m_wbad[cap_idx] = db;
                m_got[cap_idx]  = 1'b1;
                all_got = 1'b1;
                for (int i = 0; i < ND; i++) if (!m_got[i]) all_got = 1'b0;
                pub_pend = all_got;
            end
            cap_pend = 1'b0;
            zc = 0;
            zi = 0;
            for (int i = 0; i < ND; i++) begin
                if (!an_in[i]) begin
                    zc++;
                    zi = i;
                end
            end
            if (zc == 1) begin
                if (run > 0 && {an_in, seg_in} == last_pair) run++;
                else run = 1;
            end else begin
                run = 0;
            end
            last_pair = {an_in, seg_in};
            if (run == STABLE) begin
                cap_pend = 1'b1;
                cap_idx  = zi;
                cap_segv = seg_in;
            end
        end
    end

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("overrun",   32'(overrun),   32'(m_ovr));
            chk("hex_out",   32'(hex_out),   32'(m_hex));
            chk("bad_out",   32'(bad_out),   32'(m_bad));
            if (out_valid) v_cnt++;
        end
    end

    // driver tasks
    task automatic show(input int d, input logic [6:0] seg, input int cyc);
        @(negedge clk);
        an_in  = ~(ND'(1) << d);
        seg_in = seg;
        repeat (cyc - 1) @(negedge clk);
    endtask

    task automatic idle(input int cyc);
        @(negedge clk);
        an_in  = '1;
        seg_in = BLANK;
        repeat (cyc - 1) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input int cyc);
        show(0, s0, cyc);
        show(1, s1, cyc);
        show(2, s2, cyc);
        show(3, s3, cyc);
    endtask

    task automatic pulse_rst(input int cyc);
        @(negedge clk);
        rst = 1'b1;
        repeat (cyc) @(negedge clk);
        rst = 1'b0;
    endtask

    int base;

    initial begin
        rst = 1'b1;
        an_in = '1;
        seg_in = BLANK;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_hex", 32'(hex_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // idle bus
        idle(100);
        #1;
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_overrun", 32'(overrun), 32'd0);
        chk("idle_bad", 32'(bad_out), 32'd0);

        // basic scan 3,A,7,F
        base = v_cnt;
        scan(G[3], G[10], G[7], G[15], 6);
        idle(4);
        #1;
        chk("scan_hex", 32'(hex_out), 32'hF7A3);
        chk("scan_bad", 32'(bad_out), 32'h0);
        chk("scan_pulse", 32'(v_cnt - base), 32'd1);

        // short dwell on digit 1 is ignored until a full dwell arrives
        base = v_cnt;
        show(0, G[3], 6);
        show(1, G[10], 3);
        show(2, G[7], 6);
        show(3, G[15], 6);
        idle(6);
        #1;
        chk("short_nopulse", 32'(v_cnt - base), 32'd0);
        show(1, G[5], 6);
        idle(4);
        #1;
        chk("short_hex", 32'(hex_out), 32'hF753);
        chk("short_pulse", 32'(v_cnt - base), 32'd1);

        // unknown pattern on digit 2
        scan(G[3], G[10], BLANK, G[15], 6);
        idle(4);
        #1;
        chk("blank_hex", 32'(hex_out), 32'hF0A3);
        chk("blank_bad", 32'(bad_out), 32'b0100);

        // backpressure: hold, overrun, then replace on a simultaneous accept
        out_ready = 1'b0;
        scan(G[1], G[2], G[3], G[4], 6);
        idle(4);
        #1;
        chk("bp_valid1", 32'(out_valid), 32'd1);
        chk("bp_hex1", 32'(hex_out), 32'h4321);
        scan(G[5], G[6], G[7], G[8], 6);
        idle(4);
        #1;
        chk("bp_hex_held", 32'(hex_out), 32'h4321);
        chk("bp_overrun", 32'(overrun), 32'd1);
        show(0, G[9], 6);
        show(1, G[11], 6);
        show(2, G[12], 6);
        @(negedge clk);
        an_in  = 4'b0111;
        seg_in = G[13];
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("swap_valid", 32'(out_valid), 32'd1);
        chk("swap_hex", 32'(hex_out), 32'hDCB9);
        chk("swap_overrun", 32'(overrun), 32'd1);
        idle(4);

        // multiple enables, then reset in the middle of a scan
        @(negedge clk);
        an_in  = 4'b1100;
        seg_in = G[8];
        repeat (9) @(negedge clk);
        show(0, G[14], 6);
        show(1, G[0], 6);
        show(2, G[6], 2);
        pulse_rst(2);
        #1;
        chk("mid_rst_hex", 32'(hex_out), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        base = v_cnt;
        show(2, G[6], 6);
        show(3, G[2], 6);
        idle(6);
        #1;
        chk("post_rst_nopulse", 32'(v_cnt - base), 32'd0);
        scan(G[14], G[0], G[6], G[2], 6);
        idle(4);
        #1;
        chk("post_rst_hex", 32'(hex_out), 32'h260E);
        chk("post_rst_pulse", 32'(v_cnt - base), 32'd1);

        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [6:0] s;
            out_ready = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 99);
            s = ($urandom_range(0, 99) < 85) ? G[$urandom_range(0, 15)] : 7'($urandom);
            if (kind < 2) begin
                pulse_rst($urandom_range(1, 3));
            end else if (kind < 10) begin
                @(negedge clk);
                an_in  = ND'($urandom);
                seg_in = s;
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end else if (kind < 15) begin
                idle($urandom_range(1, 4));
            end else begin
                show($urandom_range(0, ND - 1), s, $urandom_range(1, 8));
            end
        end
        out_ready = 1'b1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
